// File: rtl/dm_port_arbiter_if.sv
// Signal bundle between the data-memory port arbiter, its two requesters and the DM.
// The arbiter takes the slave view; requesters plus the DM take the master view.
interface dm_port_arbiter_if #(
  parameter int DMA_SIZE = 17,
  parameter int DMD_SIZE = 16
);
  logic                core_req;
  logic                core_wrb;
  logic [DMA_SIZE-1:0] core_add;
  logic [DMD_SIZE-1:0] core_wdata;
  logic                core_gnt;
  logic                core_rvalid;

  logic                hst_req;
  logic                hst_wrb;
  logic [DMA_SIZE-1:0] hst_add;
  logic [DMD_SIZE-1:0] hst_wdata;
  logic                hst_gnt;
  logic                hst_rvalid;

  logic [DMD_SIZE-1:0] rdata;

  logic                ps_dm_cslt;
  logic                ps_dm_wrb;
  logic [DMA_SIZE-1:0] dg_dm_add;
  logic [DMD_SIZE-1:0] bc_dt;
  logic [DMD_SIZE-1:0] dm_bc_dt;

  modport master (
    output core_req, core_wrb, core_add, core_wdata,
    output hst_req, hst_wrb, hst_add, hst_wdata,
    output dm_bc_dt,
    input  core_gnt, core_rvalid, hst_gnt, hst_rvalid, rdata,
    input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt
  );

  modport slave (
    input  core_req, core_wrb, core_add, core_wdata,
    input  hst_req, hst_wrb, hst_add, hst_wdata,
    input  dm_bc_dt,
    output core_gnt, core_rvalid, hst_gnt, hst_rvalid, rdata,
    output ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Core/host arbiter and sequencer for the single data-memory port.
// Define DM_ARB_STARVE_EN to add host starvation protection (wait counter + FORCE_HST state).
module dm_port_arbiter #(
  parameter int DMA_SIZE   = 17,
  parameter int DMD_SIZE   = 16,
  parameter int STARVE_LIM = 4
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_lim_check
    $error("dm_port_arbiter: STARVE_LIM must lie in 1..15");
  end

  logic                core_gnt;
  logic                hst_gnt;
  logic                any_gnt;
  logic                sel_wrb;
  logic [DMA_SIZE-1:0] sel_add;
  logic [DMD_SIZE-1:0] sel_wdata;

  logic                cslt_q;
  logic                wrb_q;
  logic [DMA_SIZE-1:0] add_q;
  logic [DMD_SIZE-1:0] s1_data;
  logic                s1_rd;
  logic                s1_hst;
  logic [DMD_SIZE-1:0] bc_dt_q;
  logic                core_rvalid_q;
  logic                hst_rvalid_q;

`ifdef DM_ARB_STARVE_EN
  typedef enum logic {PRI_CORE, FORCE_HST} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PRI_CORE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // The switch to FORCE_HST happens on the edge where the counter reaches the limit,
  // so the host is granted in the very next cycle.
  always_comb begin
    core_gnt     = 1'b0;
    hst_gnt      = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = 4'd0;
    if (!rst) begin
      case (state)
        PRI_CORE: begin
          core_gnt = bus.core_req;
          hst_gnt  = bus.hst_req & ~bus.core_req;
        end
        FORCE_HST: begin
          hst_gnt  = bus.hst_req;
          core_gnt = bus.core_req & ~bus.hst_req;
        end
        default: begin
          core_gnt = 1'b0;
          hst_gnt  = 1'b0;
        end
      endcase
    end
    if (bus.hst_req && !hst_gnt)
      wait_cnt_nxt = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
    case (state)
      PRI_CORE:  if (wait_cnt_nxt >= LIM) state_nxt = FORCE_HST;
      FORCE_HST: if (hst_gnt || !bus.hst_req) state_nxt = PRI_CORE;
      default:   state_nxt = PRI_CORE;
    endcase
  end
`else
  always_comb begin
    core_gnt = bus.core_req & ~rst;
    hst_gnt  = bus.hst_req & ~bus.core_req & ~rst;
  end
`endif

  always_comb begin
    any_gnt   = core_gnt | hst_gnt;
    sel_wrb   = hst_gnt ? bus.hst_wrb   : bus.core_wrb;
    sel_add   = hst_gnt ? bus.hst_add   : bus.core_add;
    sel_wdata = hst_gnt ? bus.hst_wdata : bus.core_wdata;
  end

  // Stage 1 carries the command plus its read/owner tag; stage 2 launches write data
  // and raises the owner's rvalid while the DM presents its registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cslt_q        <= 1'b0;
      wrb_q         <= 1'b0;
      add_q         <= '0;
      s1_data       <= '0;
      s1_rd         <= 1'b0;
      s1_hst        <= 1'b0;
      bc_dt_q       <= '0;
      core_rvalid_q <= 1'b0;
      hst_rvalid_q  <= 1'b0;
    end else begin
      cslt_q <= any_gnt;
      s1_rd  <= any_gnt & ~sel_wrb;
      s1_hst <= hst_gnt;
      if (any_gnt) begin
        wrb_q   <= sel_wrb;
        add_q   <= sel_add;
        s1_data <= sel_wdata;
      end
      if (cslt_q && wrb_q)
        bc_dt_q <= s1_data;
      core_rvalid_q <= s1_rd & ~s1_hst;
      hst_rvalid_q  <= s1_rd & s1_hst;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.hst_gnt     = hst_gnt;
  assign bus.ps_dm_cslt  = cslt_q;
  assign bus.ps_dm_wrb   = wrb_q;
  assign bus.dg_dm_add   = add_q;
  assign bus.bc_dt       = bc_dt_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.hst_rvalid  = hst_rvalid_q;
  assign bus.rdata       = bus.dm_bc_dt;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus random traffic
// against a transaction-timeline reference model and a behavioural DM with bypass.
`timescale 1ns/1ps
module tb_dm_port_arbiter;
  localparam int DMA_SIZE   = 17;
  localparam int DMD_SIZE   = 16;
  localparam int STARVE_LIM = 4;
`ifdef DM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  dm_port_arbiter_if #(.DMA_SIZE(DMA_SIZE), .DMD_SIZE(DMD_SIZE)) bif ();

  dm_port_arbiter #(.DMA_SIZE(DMA_SIZE), .DMD_SIZE(DMD_SIZE), .STARVE_LIM(STARVE_LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DM: registered read, write committed one cycle after its command,
  // with a same-edge bypass so a read right behind a write sees the new data.
  bit [DMD_SIZE-1:0] dm_mem [0:(1<<DMA_SIZE)-1];
  bit                wr_pend = 1'b0;
  bit [DMA_SIZE-1:0] wr_pend_add = '0;
  always @(posedge clk) begin
    if (wr_pend) dm_mem[wr_pend_add] = bif.bc_dt;
    if (bif.ps_dm_cslt && !bif.ps_dm_wrb) bif.dm_bc_dt <= dm_mem[bif.dg_dm_add];
    wr_pend     = bif.ps_dm_cslt & bif.ps_dm_wrb;
    wr_pend_add = bif.dg_dm_add;
  end

  // Reference model: every grant becomes a timestamped transaction; outputs at cycle C
  // follow from the transactions granted at C-1 and C-2. Memory is updated in grant order.
  typedef struct {
    int                n;
    bit                host;
    bit                wrb;
    logic [DMA_SIZE-1:0] add;
    logic [DMD_SIZE-1:0] data;
    logic [DMD_SIZE-1:0] rd;
  } txn_t;

  txn_t              txq[$];
  bit [DMD_SIZE-1:0] ref_mem [int];
  int                blocked_run = 0;
  bit                exp_cgnt, exp_hgnt, exp_cslt, exp_wrb, exp_crv, exp_hrv;
  logic [DMA_SIZE-1:0] exp_add;
  logic [DMD_SIZE-1:0] exp_bcdt, exp_rdata;

  task automatic reset_model();
    txq.delete();
    blocked_run = 0;
  endtask

  task automatic model_cycle();
    txn_t t;
    exp_cgnt = 1'b0;
    exp_hgnt = 1'b0;
    if (bif.hst_req && (!bif.core_req || (STARVE_EN && blocked_run >= STARVE_LIM)))
      exp_hgnt = 1'b1;
    else if (bif.core_req)
      exp_cgnt = 1'b1;
    blocked_run = (bif.hst_req && !exp_hgnt) ? blocked_run + 1 : 0;

    exp_cslt = 0; exp_wrb = 0; exp_add = '0; exp_bcdt = '0;
    exp_crv = 0; exp_hrv = 0; exp_rdata = '0;
    foreach (txq[i]) begin
      if (txq[i].n <= cyc - 1) begin
        exp_wrb = txq[i].wrb;
        exp_add = txq[i].add;
      end
      if (txq[i].n == cyc - 1) exp_cslt = 1'b1;
      if (txq[i].wrb && txq[i].n <= cyc - 2) exp_bcdt = txq[i].data;
      if (!txq[i].wrb && txq[i].n == cyc - 2) begin
        exp_crv   = !txq[i].host;
        exp_hrv   = txq[i].host;
        exp_rdata = txq[i].rd;
      end
    end

    if (exp_cgnt || exp_hgnt) begin
      t.n    = cyc;
      t.host = exp_hgnt;
      t.wrb  = exp_hgnt ? bif.hst_wrb   : bif.core_wrb;
      t.add  = exp_hgnt ? bif.hst_add   : bif.core_add;
      t.data = exp_hgnt ? bif.hst_wdata : bif.core_wdata;
      t.rd   = ref_mem.exists(int'(t.add)) ? ref_mem[int'(t.add)] : '0;
      if (t.wrb) ref_mem[int'(t.add)] = t.data;
      txq.push_back(t);
    end
  endtask

  task automatic idle_inputs();
    bif.core_req = 0; bif.core_wrb = 0; bif.core_add = '0; bif.core_wdata = '0;
    bif.hst_req  = 0; bif.hst_wrb  = 0; bif.hst_add  = '0; bif.hst_wdata  = '0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif.core_req = 1; bif.hst_req = 1;
    @(negedge clk);
    checks++;
    if ({bif.core_gnt, bif.hst_gnt, bif.ps_dm_cslt, bif.ps_dm_wrb, bif.core_rvalid, bif.hst_rvalid} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {bif.core_gnt, bif.hst_gnt, bif.ps_dm_cslt, bif.ps_dm_wrb, bif.core_rvalid, bif.hst_rvalid});
    end
    checks++;
    if (bif.dg_dm_add !== '0) begin
      failures++; $display("[TB] FAIL reset_add: got %h expected 0", bif.dg_dm_add);
    end
    checks++;
    if (bif.bc_dt !== '0) begin
      failures++; $display("[TB] FAIL reset_bc_dt: got %h expected 0", bif.bc_dt);
    end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_core_read();
    bif.core_req = 1; bif.core_wrb = 0; bif.core_add = 17'h0000A;
    sample();
    checks++;
    if ({bif.core_gnt, bif.hst_gnt} !== 2'b10) begin
      failures++; $display("[TB] FAIL core_read_gnt: got %b expected 10", {bif.core_gnt, bif.hst_gnt});
    end
    next_cycle();
    idle_inputs();
    sample();
    checks++;
    if (bif.ps_dm_cslt !== 1'b1 || bif.ps_dm_wrb !== 1'b0 || bif.dg_dm_add !== 17'h0000A) begin
      failures++;
      $display("[TB] FAIL core_read_cmd: got cslt=%b wrb=%b add=%h expected 1 0 0000a",
               bif.ps_dm_cslt, bif.ps_dm_wrb, bif.dg_dm_add);
    end
    next_cycle();
    sample();
    checks++;
    if (bif.core_rvalid !== 1'b1 || bif.hst_rvalid !== 1'b0 || bif.rdata !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL core_read_data: got crv=%b hrv=%b rdata=%h expected 1 0 1234",
               bif.core_rvalid, bif.hst_rvalid, bif.rdata);
    end
    next_cycle();
  endtask

  task automatic test_write_bypass();
    bif.hst_req = 1; bif.hst_wrb = 1; bif.hst_add = 17'h0000F; bif.hst_wdata = 16'hFFEE;
    sample();
    checks++;
    if ({bif.core_gnt, bif.hst_gnt} !== 2'b01) begin
      failures++; $display("[TB] FAIL bypass_hst_gnt: got %b expected 01", {bif.core_gnt, bif.hst_gnt});
    end
    next_cycle();
    idle_inputs();
    bif.core_req = 1; bif.core_wrb = 0; bif.core_add = 17'h0000F;
    sample();
    checks++;
    if (bif.core_gnt !== 1'b1 || bif.ps_dm_cslt !== 1'b1 || bif.ps_dm_wrb !== 1'b1 || bif.dg_dm_add !== 17'h0000F) begin
      failures++;
      $display("[TB] FAIL bypass_wr_cmd: got gnt=%b cslt=%b wrb=%b add=%h expected 1 1 1 0000f",
               bif.core_gnt, bif.ps_dm_cslt, bif.ps_dm_wrb, bif.dg_dm_add);
    end
    next_cycle();
    idle_inputs();
    sample();
    checks++;
    if (bif.bc_dt !== 16'hFFEE || bif.ps_dm_cslt !== 1'b1 || bif.ps_dm_wrb !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bypass_wdata: got bc_dt=%h cslt=%b wrb=%b expected ffee 1 0",
               bif.bc_dt, bif.ps_dm_cslt, bif.ps_dm_wrb);
    end
    next_cycle();
    sample();
    checks++;
    if (bif.core_rvalid !== 1'b1 || bif.rdata !== 16'hFFEE) begin
      failures++; $display("[TB] FAIL bypass_rdata: got crv=%b rdata=%h expected 1 ffee", bif.core_rvalid, bif.rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    bit exp_h;
    bif.core_req = 1; bif.core_wrb = 0; bif.core_add = 17'h00010;
    bif.hst_req  = 1; bif.hst_wrb  = 0; bif.hst_add  = 17'h00020;
    for (int t = 0; t < 20; t++) begin
      sample();
      exp_h = STARVE_EN && (t % (STARVE_LIM + 1) == STARVE_LIM);
      checks++;
      if (bif.hst_gnt !== exp_h) begin
        failures++; $display("[TB] FAIL starve_hst_gnt t=%0d: got %b expected %b", t, bif.hst_gnt, exp_h);
      end
      checks++;
      if (bif.core_gnt !== !exp_h) begin
        failures++; $display("[TB] FAIL starve_core_gnt t=%0d: got %b expected %b", t, bif.core_gnt, !exp_h);
      end
      checks++;
      if ({bif.core_rvalid, bif.hst_rvalid} !== {exp_crv, exp_hrv}) begin
        failures++;
        $display("[TB] FAIL starve_rvalid t=%0d: got %b expected %b", t,
                 {bif.core_rvalid, bif.hst_rvalid}, {exp_crv, exp_hrv});
      end
      next_cycle();
    end
    idle_inputs();
    for (int t = 0; t < 2; t++) begin
      sample();
      next_cycle();
    end
  endtask

  task automatic test_alternating();
    logic [DMD_SIZE-1:0] wd [8];
    bit exp_h;
    for (int t = 0; t < 11; t++) begin
      idle_inputs();
      if (t < 8 && t % 2 == 0) begin
        wd[t] = 16'($urandom);
        bif.core_req = 1; bif.core_wrb = 1; bif.core_add = DMA_SIZE'(17'h30 + t); bif.core_wdata = wd[t];
      end else if (t < 8) begin
        bif.hst_req = 1; bif.hst_wrb = 0; bif.hst_add = DMA_SIZE'(17'h30 + t - 1);
      end
      sample();
      checks++;
      if (bif.ps_dm_cslt !== (t >= 1 && t <= 8)) begin
        failures++; $display("[TB] FAIL alt_cslt t=%0d: got %b expected %b", t, bif.ps_dm_cslt, (t >= 1 && t <= 8));
      end
      if (t >= 2 && t <= 9) begin
        checks++;
        if (bif.bc_dt !== wd[(t % 2 == 0) ? t - 2 : t - 3]) begin
          failures++;
          $display("[TB] FAIL alt_bc_dt t=%0d: got %h expected %h", t, bif.bc_dt, wd[(t % 2 == 0) ? t - 2 : t - 3]);
        end
      end
      exp_h = (t >= 3 && t <= 9 && t % 2 == 1);
      checks++;
      if (bif.hst_rvalid !== exp_h || bif.core_rvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL alt_rvalid t=%0d: got crv=%b hrv=%b expected 0 %b", t, bif.core_rvalid, bif.hst_rvalid, exp_h);
      end
      if (exp_h) begin
        checks++;
        if (bif.rdata !== wd[t - 3]) begin
          failures++; $display("[TB] FAIL alt_rdata t=%0d: got %h expected %h", t, bif.rdata, wd[t - 3]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    bit cp = 0;
    bit hp = 0;
    for (int n = 0; n < 300; n++) begin
      if (!cp && $urandom_range(99) < 60) begin
        cp = 1;
        bif.core_wrb   = 1'($urandom_range(1));
        bif.core_add   = DMA_SIZE'(32'h40 + $urandom_range(15));
        bif.core_wdata = 16'($urandom);
      end
      if (!hp && $urandom_range(99) < 50) begin
        hp = 1;
        bif.hst_wrb   = 1'($urandom_range(1));
        bif.hst_add   = DMA_SIZE'(32'h40 + $urandom_range(15));
        bif.hst_wdata = 16'($urandom);
      end
      bif.core_req = cp;
      bif.hst_req  = hp;
      sample();
      checks++;
      if ({bif.core_gnt, bif.hst_gnt} !== {exp_cgnt, exp_hgnt}) begin
        failures++;
        $display("[TB] FAIL rand_gnt n=%0d: got %b expected %b", n, {bif.core_gnt, bif.hst_gnt}, {exp_cgnt, exp_hgnt});
      end
      checks++;
      if ({bif.ps_dm_cslt, bif.ps_dm_wrb, bif.dg_dm_add} !== {exp_cslt, exp_wrb, exp_add}) begin
        failures++;
        $display("[TB] FAIL rand_cmd n=%0d: got cslt=%b wrb=%b add=%h expected %b %b %h", n,
                 bif.ps_dm_cslt, bif.ps_dm_wrb, bif.dg_dm_add, exp_cslt, exp_wrb, exp_add);
      end
      checks++;
      if (bif.bc_dt !== exp_bcdt) begin
        failures++; $display("[TB] FAIL rand_bc_dt n=%0d: got %h expected %h", n, bif.bc_dt, exp_bcdt);
      end
      checks++;
      if ({bif.core_rvalid, bif.hst_rvalid} !== {exp_crv, exp_hrv}) begin
        failures++;
        $display("[TB] FAIL rand_rvalid n=%0d: got %b expected %b", n, {bif.core_rvalid, bif.hst_rvalid}, {exp_crv, exp_hrv});
      end
      if (exp_crv || exp_hrv) begin
        checks++;
        if (bif.rdata !== exp_rdata) begin
          failures++; $display("[TB] FAIL rand_rdata n=%0d: got %h expected %h", n, bif.rdata, exp_rdata);
        end
      end
      if (exp_cgnt) cp = 0;
      if (exp_hgnt) hp = 0;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    for (int t = 0; t < 3; t++) begin
      sample();
      next_cycle();
    end
    bif.core_req = 1; bif.core_wrb = 0; bif.core_add = 17'h0000A;
    sample();
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bif.core_gnt, bif.hst_gnt, bif.ps_dm_cslt, bif.ps_dm_wrb, bif.core_rvalid, bif.hst_rvalid} !== 6'b0
        || bif.dg_dm_add !== '0 || bif.bc_dt !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got ctrl=%b add=%h bc_dt=%h expected all 0",
               {bif.core_gnt, bif.hst_gnt, bif.ps_dm_cslt, bif.ps_dm_wrb, bif.core_rvalid, bif.hst_rvalid},
               bif.dg_dm_add, bif.bc_dt);
    end
    reset_model();
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      sample();
      checks++;
      if (bif.core_rvalid !== 1'b0 || bif.hst_rvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_rvalid t=%0d: got crv=%b hrv=%b expected 0 0", t, bif.core_rvalid, bif.hst_rvalid);
      end
      next_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    bif.dm_bc_dt = '0;
    dm_mem[17'h0000A]   = 16'h1234;
    ref_mem[32'h0000A]  = 16'h1234;
    test_reset();
    test_core_read();
    test_write_bypass();
    test_starvation();
    test_alternating();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
